// File: rtl/clk_div_gen_pkg.sv
// Shared types and constants for the clk_div_gen clock divider bank.
package clk_div_gen_pkg;

    // Per-channel run state.
    typedef enum logic [0:0] {
        StIdle,
        StRun
    } chan_state_e;

    // Default reset divide value for every channel.
    localparam int unsigned DEF_DIV_DFLT = 10;

    // Clamp limits: a period shorter than 2 cannot hold both a high and a low phase.
    localparam int unsigned MIN_DIV  = 2;
    localparam int unsigned MIN_HIGH = 1;

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: IDLE/RUN control, period counter, shadowed divide/high-time
// configuration applied only on period boundaries, registered clk/tick outputs.
// Optional macro CLK_DIV_GEN_ALIGN_EN adds the 'align' restart input.
module clk_div_chan
    import clk_div_gen_pkg::*;
#(
    parameter int unsigned DIV_W   = 16,
    parameter int unsigned DEF_DIV = DEF_DIV_DFLT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lock_ok,
    input  logic             en,
    input  logic             we,
    input  logic [DIV_W-1:0] wr_div,
    input  logic [DIV_W-1:0] wr_high,
`ifdef CLK_DIV_GEN_ALIGN_EN
    input  logic             align,
`endif
    output logic             clk_o,
    output logic             tick_o,
    output logic             pend_o
);

    localparam logic [DIV_W-1:0] RstDiv  = DIV_W'(DEF_DIV);
    localparam logic [DIV_W-1:0] RstHigh = DIV_W'(DEF_DIV / 2);
    localparam logic [DIV_W-1:0] MinDiv  = DIV_W'(MIN_DIV);
    localparam logic [DIV_W-1:0] MinHigh = DIV_W'(MIN_HIGH);
    localparam logic [DIV_W-1:0] One     = DIV_W'(1);

    chan_state_e      state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] high_q, high_d;
    logic [DIV_W-1:0] pdiv_q, pdiv_d;
    logic [DIV_W-1:0] phigh_q, phigh_d;
    logic             pend_q, pend_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;

    logic [DIV_W-1:0] wr_div_eff;
    logic [DIV_W-1:0] wr_high_eff;
    logic             do_align;
    logic             apply;

`ifdef CLK_DIV_GEN_ALIGN_EN
    assign do_align = align;
`else
    assign do_align = 1'b0;
`endif

    // Next state: counter, boundary-gated config apply, pending capture, next outputs.
    always_comb begin
        wr_div_eff  = (wr_div < MinDiv) ? MinDiv : wr_div;
        wr_high_eff = (wr_high < MinHigh)          ? MinHigh :
                      (wr_high > wr_div_eff - One) ? wr_div_eff - One : wr_high;

        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        high_d  = high_q;
        pdiv_d  = pdiv_q;
        phigh_d = phigh_q;
        pend_d  = pend_q;
        apply   = 1'b0;

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                apply = pend_q;
                if (en && lock_ok) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (!en || !lock_ok) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q == div_q - One || do_align) begin
                    cnt_d = '0;
                    apply = pend_q;
                end else begin
                    cnt_d = cnt_q + One;
                end
            end
            default: state_d = StIdle;
        endcase

        if (apply) begin
            div_d  = pdiv_q;
            high_d = phigh_q;
            pend_d = 1'b0;
        end

        // A write coinciding with an apply is held over to the next boundary.
        if (we) begin
            pdiv_d  = wr_div_eff;
            phigh_d = wr_high_eff;
            pend_d  = 1'b1;
        end

        clk_d  = (state_d == StRun) && (cnt_d < high_d);
        tick_d = (state_d == StRun) && (cnt_d == '0);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            div_q   <= RstDiv;
            high_q  <= RstHigh;
            pdiv_q  <= RstDiv;
            phigh_q <= RstHigh;
            pend_q  <= 1'b0;
            clk_q   <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            high_q  <= high_d;
            pdiv_q  <= pdiv_d;
            phigh_q <= phigh_d;
            pend_q  <= pend_d;
            clk_q   <= clk_d;
            tick_q  <= tick_d;
        end
    end

    assign clk_o  = clk_q;
    assign tick_o = tick_q;
    assign pend_o = pend_q;

endmodule

// File: rtl/clk_div_gen.sv
// Multi-channel programmable clock divider with PLL lock qualification.
// Optional macro CLK_DIV_GEN_ALIGN_EN adds the 'align' input that restarts all
// running channels at count 0 together.
module clk_div_gen
    import clk_div_gen_pkg::*;
#(
    parameter int unsigned CH_NUM    = 4,
    parameter int unsigned DIV_W     = 16,
    parameter int unsigned LOCK_WAIT = 16,
    parameter int unsigned DEF_DIV   = DEF_DIV_DFLT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              locked,
    input  logic [CH_NUM-1:0] ch_en,
    input  logic              cfg_we,
    input  logic [3:0]        cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic [DIV_W-1:0]  cfg_high,
`ifdef CLK_DIV_GEN_ALIGN_EN
    input  logic              align,
`endif
    output logic [CH_NUM-1:0] clk_o,
    output logic [CH_NUM-1:0] tick_o,
    output logic [CH_NUM-1:0] pend_o,
    output logic              lock_ok
);

    localparam int unsigned LockCw = (LOCK_WAIT > 0) ? $clog2(LOCK_WAIT + 1) : 1;
    localparam logic [LockCw-1:0] LockMax = LockCw'(LOCK_WAIT);

    logic [LockCw-1:0] lock_cnt_q, lock_cnt_d;
    logic [CH_NUM-1:0] ch_we;

    // Lock streak counter, saturating at LOCK_WAIT, cleared whenever locked drops.
    always_comb begin
        lock_cnt_d = lock_cnt_q;
        if (!locked) begin
            lock_cnt_d = '0;
        end else if (lock_cnt_q != LockMax) begin
            lock_cnt_d = lock_cnt_q + LockCw'(1);
        end
    end

    // Lock counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_cnt_q <= '0;
        end else begin
            lock_cnt_q <= lock_cnt_d;
        end
    end

    assign lock_ok = (lock_cnt_q == LockMax);

    // Write decode; indices beyond CH_NUM match no channel and are dropped.
    always_comb begin
        ch_we = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            ch_we[i] = cfg_we && (cfg_ch == 4'(i));
        end
    end

    for (genvar i = 0; i < CH_NUM; i++) begin : g_chan
        clk_div_chan #(
            .DIV_W   (DIV_W),
            .DEF_DIV (DEF_DIV)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .lock_ok (lock_ok),
            .en      (ch_en[i]),
            .we      (ch_we[i]),
            .wr_div  (cfg_div),
            .wr_high (cfg_high),
`ifdef CLK_DIV_GEN_ALIGN_EN
            .align   (align),
`endif
            .clk_o   (clk_o[i]),
            .tick_o  (tick_o[i]),
            .pend_o  (pend_o[i])
        );
    end

endmodule

// File: tb/tb_clk_div_gen.sv
// Self-checking bench for clk_div_gen: directed scenarios plus randomized traffic,
// all compared cycle by cycle against a behavioural model of the divider bank.
module tb_clk_div_gen;

    localparam int unsigned CH_NUM    = 4;
    localparam int unsigned DIV_W     = 16;
    localparam int unsigned LOCK_WAIT = 16;
    localparam int unsigned DEF_DIV   = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic              locked;
    logic [CH_NUM-1:0] ch_en;
    logic              cfg_we;
    logic [3:0]        cfg_ch;
    logic [DIV_W-1:0]  cfg_div;
    logic [DIV_W-1:0]  cfg_high;
`ifdef CLK_DIV_GEN_ALIGN_EN
    logic              align;
`endif
    logic [CH_NUM-1:0] clk_o;
    logic [CH_NUM-1:0] tick_o;
    logic [CH_NUM-1:0] pend_o;
    logic              lock_ok;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    clk_div_gen #(
        .CH_NUM    (CH_NUM),
        .DIV_W     (DIV_W),
        .LOCK_WAIT (LOCK_WAIT),
        .DEF_DIV   (DEF_DIV)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .locked   (locked),
        .ch_en    (ch_en),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_div  (cfg_div),
        .cfg_high (cfg_high),
`ifdef CLK_DIV_GEN_ALIGN_EN
        .align    (align),
`endif
        .clk_o    (clk_o),
        .tick_o   (tick_o),
        .pend_o   (pend_o),
        .lock_ok  (lock_ok)
    );

    // Behavioural model: position within the current period, active and pending periods.
    int streak;
    bit m_run [CH_NUM];
    int m_pos [CH_NUM];
    int m_d   [CH_NUM];
    int m_h   [CH_NUM];
    bit m_pv  [CH_NUM];
    int m_pd  [CH_NUM];
    int m_ph  [CH_NUM];

    function automatic int eff_d(input int v);
        return (v < 2) ? 2 : v;
    endfunction

    function automatic int eff_h(input int v, input int d);
        if (v < 1) return 1;
        if (v > d - 1) return d - 1;
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    function automatic void model_update();
        bit lk;
        bit apply;
        bit do_align;
        do_align = 1'b0;
`ifdef CLK_DIV_GEN_ALIGN_EN
        do_align = align;
`endif
        if (rst) begin
            streak = 0;
            for (int i = 0; i < CH_NUM; i++) begin
                m_run[i] = 1'b0;
                m_pos[i] = 0;
                m_d[i]   = DEF_DIV;
                m_h[i]   = DEF_DIV / 2;
                m_pv[i]  = 1'b0;
            end
            return;
        end
        lk = (streak >= LOCK_WAIT);
        for (int i = 0; i < CH_NUM; i++) begin
            apply = 1'b0;
            if (!m_run[i]) begin
                apply = m_pv[i];
                if (ch_en[i] && lk) begin
                    m_run[i] = 1'b1;
                    m_pos[i] = 0;
                end
            end else if (!ch_en[i] || !lk) begin
                m_run[i] = 1'b0;
                m_pos[i] = 0;
            end else begin
                m_pos[i] = (m_pos[i] + 1) % m_d[i];
                if (do_align) m_pos[i] = 0;
                if (m_pos[i] == 0) apply = m_pv[i];
            end
            if (apply) begin
                m_d[i]  = m_pd[i];
                m_h[i]  = m_ph[i];
                m_pv[i] = 1'b0;
            end
            if (cfg_we && (int'(cfg_ch) == i)) begin
                m_pv[i] = 1'b1;
                m_pd[i] = eff_d(int'(cfg_div));
                m_ph[i] = eff_h(int'(cfg_high), m_pd[i]);
            end
        end
        streak = locked ? streak + 1 : 0;
    endfunction

    task automatic compare();
        logic [CH_NUM-1:0] e_clk, e_tick, e_pend;
        for (int i = 0; i < CH_NUM; i++) begin
            e_clk[i]  = m_run[i] && (m_pos[i] < m_h[i]);
            e_tick[i] = m_run[i] && (m_pos[i] == 0);
            e_pend[i] = m_pv[i];
        end
        check("clk_o", 32'(clk_o), 32'(e_clk));
        check("tick_o", 32'(tick_o), 32'(e_tick));
        check("pend_o", 32'(pend_o), 32'(e_pend));
        check("lock_ok", 32'(lock_ok), 32'(streak >= LOCK_WAIT));
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic cfg_write(input int ch, input int dv, input int hi);
        cfg_we   = 1'b1;
        cfg_ch   = 4'(ch);
        cfg_div  = DIV_W'(dv);
        cfg_high = DIV_W'(hi);
        step();
        cfg_we   = 1'b0;
    endtask

    task automatic wait_pend_clear(input int ch);
        int n = 0;
        while (pend_o[ch] && n < 64) begin
            step();
            n++;
        end
        check("pend_clear_timeout", 32'(pend_o[ch]), 32'd0);
    endtask

    // Period and high-time of the first full period starting at the next tick.
    task automatic measure(input int ch, output int period, output int high);
        int n = 0;
        while (!tick_o[ch] && n < 64) begin
            step();
            n++;
        end
        if (!tick_o[ch]) begin
            period = -1;
            high   = -1;
            return;
        end
        period = 1;
        high   = int'(clk_o[ch]);
        step();
        n = 0;
        while (!tick_o[ch] && n < 64) begin
            period++;
            high += int'(clk_o[ch]);
            step();
            n++;
        end
        if (!tick_o[ch]) period = -1;
    endtask

    initial begin
        int first_lock, first_clk, p, h, n, idx;

        rst      = 1'b1;
        locked   = 1'b1;
        ch_en    = '1;
        cfg_we   = 1'b0;
        cfg_ch   = '0;
        cfg_div  = '0;
        cfg_high = '0;
`ifdef CLK_DIV_GEN_ALIGN_EN
        align    = 1'b0;
`endif
        repeat (3) step();
        check("rst_clk_o", 32'(clk_o), 32'd0);
        check("rst_tick_o", 32'(tick_o), 32'd0);
        check("rst_pend_o", 32'(pend_o), 32'd0);
        check("rst_lock_ok", 32'(lock_ok), 32'd0);

        // Lock qualification and first period after reset.
        rst        = 1'b0;
        first_lock = -1;
        first_clk  = -1;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (lock_ok && first_lock < 0) first_lock = k;
            if (clk_o[0] && first_clk < 0) first_clk = k;
        end
        check("lock_cycle", 32'(first_lock), 32'(LOCK_WAIT));
        check("first_high_cycle", 32'(first_clk), 32'(LOCK_WAIT + 1));
        measure(0, p, h);
        check("def_period", 32'(p), 32'd10);
        check("def_high", 32'(h), 32'd5);

        // Reconfigure ch1 mid-period: applied only at the boundary.
        cfg_write(1, 4, 1);
        check("pend1_set", 32'(pend_o[1]), 32'd1);
        wait_pend_clear(1);
        check("tick_at_apply", 32'(tick_o[1]), 32'd1);
        measure(1, p, h);
        check("ch1_period", 32'(p), 32'd4);
        check("ch1_high", 32'(h), 32'd1);

        // Clamping of divide and high time.
        cfg_write(2, 0, 0);
        wait_pend_clear(2);
        measure(2, p, h);
        check("clamp_min_period", 32'(p), 32'd2);
        check("clamp_min_high", 32'(h), 32'd1);
        cfg_write(3, 5, 9);
        wait_pend_clear(3);
        measure(3, p, h);
        check("clamp_hi_period", 32'(p), 32'd5);
        check("clamp_hi_high", 32'(h), 32'd4);

        // Out-of-range channel index is ignored.
        cfg_write(7, 3, 1);
        check("ch7_ignored", 32'(pend_o), 32'd0);

        // One-cycle lock loss stops all channels, then requalification.
        locked = 1'b0;
        step();
        locked = 1'b1;
        step();
        check("drop_clk_low", 32'(clk_o), 32'd0);
        n = 1;
        while (!clk_o[0] && n < 64) begin
            step();
            n++;
        end
        check("relock_cycles", 32'(n), 32'(LOCK_WAIT + 1));

`ifdef CLK_DIV_GEN_ALIGN_EN
        cfg_write(0, 3, 1);
        cfg_write(1, 7, 3);
        wait_pend_clear(0);
        wait_pend_clear(1);
        repeat (5) step();
        align = 1'b1;
        step();
        align = 1'b0;
        check("align_ticks", 32'(tick_o[1:0]), 32'd3);
`endif

        // Randomized traffic against the model.
        for (int k = 0; k < 1500; k++) begin
            rst    = ($urandom_range(0, 499) == 0);
            locked = ($urandom_range(0, 79) != 0);
            if ($urandom_range(0, 29) == 0) begin
                idx        = $urandom_range(0, CH_NUM - 1);
                ch_en[idx] = ~ch_en[idx];
            end
            cfg_we   = ($urandom_range(0, 5) == 0);
            cfg_ch   = 4'($urandom_range(0, 7));
            cfg_div  = DIV_W'($urandom_range(0, 12));
            cfg_high = DIV_W'($urandom_range(0, 14));
`ifdef CLK_DIV_GEN_ALIGN_EN
            align    = ($urandom_range(0, 60) == 0);
`endif
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
